branch_decode: RTL and testbench
================================

# branch_decode

Branch and condition-flag control for the LEGv8 datapath. It takes the registered instruction from the fetch path and the ALU status, and drives `BrTaken` and `UncondBr` back into the fetch path's next-PC muxes. It holds the architectural NZVC flag register and squashes wrong-path instructions after a taken branch. It also keeps a saturating count of taken branches for debug.

## Interface
- `SQUASH_SLOTS`, default 1: number of instructions invalidated after a taken branch; legal range 0–3.
- `CNT_W`, default 16: width of the taken-branch counter.

- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `instruction`  in  32  instruction currently issuing.
- `instr_valid`  in  1  `instruction` is real; low means a bubble.
- `cbz_zero`  in  1  the register read for CBZ's Rt equals zero.
- `alu_n`, `alu_z`, `alu_v`, `alu_c`  in  1 each  flags from the current ALU result.
- `BrTaken`  out  1  next PC = PC + (selected offset << 2).
- `UncondBr`  out  1  1 selects the 26-bit B offset; 0 selects the 19-bit CBZ/B.cond offset.
- `flags`  out  4  registered {N,Z,V,C}.
- `squash`  out  1  the current instruction is wrong-path and is being ignored.
- `taken_count`  out  `CNT_W`  saturating count of taken branches.

## Operation
- Effective valid: `eff_valid = instr_valid & ~squash`.
- Opcode decode (only when `eff_valid`):
  - B: `instruction[31:26]=000101`.
  - CBZ: `[31:24]=10110100`.
  - B.cond: `[31:24]=01010100`, condition code in `[3:0]`.
  - ADDS: `[31:21]=10101011000`.
  - SUBS: `[31:21]=11101011000`.
  - Any other opcode: not a branch, no flag write.
- Branch resolution:
  - B: `BrTaken=1`, `UncondBr=1`.
  - CBZ: `BrTaken=cbz_zero`, `UncondBr=0`.
  - B.cond: `BrTaken=cond_true(flags)`, `UncondBr=0`.
  - Otherwise: both outputs 0.
- `cond_true` uses the ARM encoding:
  - EQ Z; NE !Z; HS C; LO !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - 1110 and 1111 are always true.
- B.cond reads the **registered** flags. There is no forwarding from `alu_*`; an ADDS/SUBS followed immediately by B.cond sees the updated flags because the flag write happens at the ADDS edge.
- Flag register: on the clock edge, if `eff_valid` and the opcode is ADDS or SUBS, `flags <= {alu_n,alu_z,alu_v,alu_c}`. Otherwise the flags hold.
- Squash FSM, states IDLE and SQUASHING, with a 2-bit remaining-count `sq_cnt`:
  - In IDLE, a taken branch with `SQUASH_SLOTS>0` moves the FSM to SQUASHING with `sq_cnt=SQUASH_SLOTS`.
  - In SQUASHING, each edge with `instr_valid=1` decrements `sq_cnt`. Edges with `instr_valid=0` do not decrement, because bubbles do not consume slots.
  - The FSM returns to IDLE when `sq_cnt` reaches 0.
  - `squash = (state==SQUASHING)`.
  - A squashed instruction never branches, never writes flags, and never counts.
  - With `SQUASH_SLOTS=0` the FSM never leaves IDLE.
- `taken_count` increments on each edge where `BrTaken=1`, and saturates at all-ones.

## Timing
- `BrTaken` and `UncondBr` are combinational from `instruction`, `instr_valid`, `cbz_zero`, the registered `flags` and `squash`. There is zero-cycle latency into the next-PC mux.
- `flags`, `squash` and `taken_count` are registered; each updates on the rising `clk` edge.
- While `rst=0` (asynchronous, immediate):
  - `flags=0000`;
  - FSM in IDLE with `sq_cnt=0`, so `squash=0`;
  - `taken_count=0`;
  - `BrTaken=0` and `UncondBr=0`, because `squash=0` and decode is gated by `instr_valid`. The bench holds `instr_valid=0` during reset.
- Reset asserted mid-squash aborts the squash; the first instruction after reset release is not squashed.
- A branch and a flag-setting opcode cannot share an encoding, so there is no simultaneous branch and flag write.

## Structure
- Shared package `legv8_pkg` holds:
  - opcode constants `OP_B`, `OP_CBZ`, `OP_BCOND`, `OP_ADDS`, `OP_SUBS`;
  - the condition-code enum `cond_e`;
  - the flags struct `nzvc_t`;
  - the squash-state enum `sq_state_e`.
- The `cond_true` evaluation is one natural combinational sub-module, `cond_eval`, with inputs `nzvc_t` and `cond_e` and a 1-bit output.

## Test plan
- **Reset:** drive `rst=0` mid-clock → `flags=0`, `squash=0` and `taken_count=0` immediately; `BrTaken=0`.
- **Flags then branch:** SUBS with `alu_n=1,alu_z=0,alu_v=0,alu_c=0`, then B.LT (cond 1011) → `flags=1000` after the SUBS edge; during the B.LT cycle `BrTaken=1`, `UncondBr=0`, and on the next cycle `squash=1` for exactly 1 valid instruction.
- **Squashed instructions have no effect:** a squashed ADDS with `alu_z=1` and a squashed B → `flags` unchanged, `BrTaken=0`, `taken_count` unchanged.
- **CBZ:** CBZ with `cbz_zero=0` → `BrTaken=0`, no squash; with `cbz_zero=1` → `BrTaken=1`, `UncondBr=0`, `taken_count` +1.
- **Squash with bubbles:** B (`UncondBr=1`) with `SQUASH_SLOTS=2` and bubbles interleaved in the following cycles → squash lasts until 2 valid instructions have been dropped.
- **Counter saturation:** `CNT_W=4`, 20 consecutive taken B instructions → `taken_count` sticks at 15.

Source files
------------

// File: rtl/legv8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : legv8_pkg
//  Description : Shared opcode constants, condition-code enum, NZVC flag
//                struct and squash-state enum for the LEGv8 branch logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package legv8_pkg;

  // Opcode fields, compared against the top bits of the instruction word
  localparam logic [5:0]  OP_B     = 6'b000101;      // [31:26]
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;    // [31:24]
  localparam logic [7:0]  OP_BCOND = 8'b01010100;    // [31:24]
  localparam logic [10:0] OP_ADDS  = 11'b10101011000; // [31:21]
  localparam logic [10:0] OP_SUBS  = 11'b11101011000; // [31:21]

  // ARM condition-code encoding carried in B.cond bits [3:0]
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_HS = 4'b0010,
    COND_LO = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // Architectural flags, packed MSB-first as {N,Z,V,C}
  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } nzvc_t;

  // Wrong-path squash FSM
  typedef enum logic [0:0] {
    SQ_IDLE      = 1'b0,
    SQ_SQUASHING = 1'b1
  } sq_state_e;

endpackage : legv8_pkg
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
//  Module      : cond_eval
//  Description : Combinational evaluation of an ARM condition code against
//                the registered NZVC flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
  import legv8_pkg::*;
(
  input  nzvc_t i_flags,
  input  cond_e i_cond,
  output logic  o_taken
);

  // Decode the condition against the flag register; AL and NV always pass
  always_comb begin
    o_taken = 1'b1;
    case (i_cond)
      COND_EQ: o_taken = i_flags.z;
      COND_NE: o_taken = ~i_flags.z;
      COND_HS: o_taken = i_flags.c;
      COND_LO: o_taken = ~i_flags.c;
      COND_MI: o_taken = i_flags.n;
      COND_PL: o_taken = ~i_flags.n;
      COND_VS: o_taken = i_flags.v;
      COND_VC: o_taken = ~i_flags.v;
      COND_HI: o_taken = i_flags.c & ~i_flags.z;
      COND_LS: o_taken = ~i_flags.c | i_flags.z;
      COND_GE: o_taken = (i_flags.n == i_flags.v);
      COND_LT: o_taken = (i_flags.n != i_flags.v);
      COND_GT: o_taken = ~i_flags.z & (i_flags.n == i_flags.v);
      COND_LE: o_taken = i_flags.z | (i_flags.n != i_flags.v);
      COND_AL: o_taken = 1'b1;
      COND_NV: o_taken = 1'b1;
      default: o_taken = 1'b1;
    endcase
  end

endmodule : cond_eval
`default_nettype wire

// File: rtl/branch_decode.sv
`default_nettype none
// ============================================================================
//  Module      : branch_decode
//  Description : LEGv8 branch resolution, NZVC flag register, wrong-path
//                squash after taken branches and a saturating taken-branch
//                counter for debug.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_decode #(
  parameter int SQUASH_SLOTS = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  input  logic [31:0]       instruction,
  input  logic              instr_valid,
  input  logic              cbz_zero,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_v,
  input  logic              alu_c,
  output logic              BrTaken,
  output logic              UncondBr,
  output logic [3:0]        flags,
  output logic              squash,
  output logic [CNT_W-1:0]  taken_count
);
  import legv8_pkg::*;

  localparam logic [1:0] C_SQ_INIT = 2'(SQUASH_SLOTS);
  localparam logic       C_SQ_EN   = (SQUASH_SLOTS > 0);

  logic             eff_valid;
  logic             is_b;
  logic             is_cbz;
  logic             is_bcond;
  logic             is_flag_set;
  logic             cond_hit;
  nzvc_t            flags_q,  flags_d;
  sq_state_e        state_q,  state_d;
  logic [1:0]       sq_cnt_q, sq_cnt_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Offset and register-number fields play no part in branch resolution
  logic unused_bits;
  assign unused_bits = ^instruction[20:4];

  cond_eval u_cond_eval (
    .i_flags (flags_q),
    .i_cond  (cond_e'(instruction[3:0])),
    .o_taken (cond_hit)
  );

  // Opcode decode and zero-latency branch resolution into the next-PC mux
  always_comb begin
    eff_valid   = instr_valid & (state_q != SQ_SQUASHING);
    is_b        = eff_valid & (instruction[31:26] == OP_B);
    is_cbz      = eff_valid & (instruction[31:24] == OP_CBZ);
    is_bcond    = eff_valid & (instruction[31:24] == OP_BCOND);
    is_flag_set = eff_valid & ((instruction[31:21] == OP_ADDS) |
                               (instruction[31:21] == OP_SUBS));
    BrTaken     = is_b | (is_cbz & cbz_zero) | (is_bcond & cond_hit);
    UncondBr    = is_b;
  end

  // Next-state for flags, squash FSM and taken counter
  always_comb begin
    flags_d  = flags_q;
    state_d  = state_q;
    sq_cnt_d = sq_cnt_q;
    count_d  = count_q;

    if (is_flag_set) begin
      flags_d = '{n: alu_n, z: alu_z, v: alu_v, c: alu_c};
    end

    case (state_q)
      SQ_IDLE: begin
        if (BrTaken && C_SQ_EN) begin
          state_d  = SQ_SQUASHING;
          sq_cnt_d = C_SQ_INIT;
        end
      end
      SQ_SQUASHING: begin
        // Bubbles do not occupy a wrong-path slot, so only valid slots count
        if (instr_valid) begin
          sq_cnt_d = sq_cnt_q - 2'd1;
          if (sq_cnt_q == 2'd1) begin
            state_d = SQ_IDLE;
          end
        end
      end
      default: begin
        state_d  = SQ_IDLE;
        sq_cnt_d = 2'd0;
      end
    endcase

    if (BrTaken && !(&count_q)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // State registers; reset aborts any squash in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q  <= '0;
      state_q  <= SQ_IDLE;
      sq_cnt_q <= 2'd0;
      count_q  <= '0;
    end else begin
      flags_q  <= flags_d;
      state_q  <= state_d;
      sq_cnt_q <= sq_cnt_d;
      count_q  <= count_d;
    end
  end

  assign flags       = flags_q;
  assign squash      = (state_q == SQ_SQUASHING);
  assign taken_count = count_q;

endmodule : branch_decode
`default_nettype wire

// File: tb/tb_branch_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_decode
//  Description : Self-checking bench for branch_decode. Three instances share
//                stimulus: default parameters, SQUASH_SLOTS=2, and
//                SQUASH_SLOTS=0 with a 4-bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_decode;

  localparam logic [31:0] I_B    = {6'b000101, 26'd16};
  localparam logic [31:0] I_CBZ  = {8'hB4, 19'd4, 5'd1};
  localparam logic [31:0] I_ADDS = {11'b10101011000, 21'd0};
  localparam logic [31:0] I_SUBS = {11'b11101011000, 21'd0};
  localparam logic [31:0] I_NOP  = {11'b10001011000, 21'd0};

  function automatic logic [31:0] bcond(input logic [3:0] c);
    return {8'h54, 19'd3, 1'b0, c};
  endfunction

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        cbz_zero;
  logic [3:0]  alu;
  logic [2:0]  br_o, ub_o, sq_o;
  logic [3:0]  fl0, fl1, fl2;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  branch_decode u_dut0 (
    .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
    .cbz_zero(cbz_zero), .alu_n(alu[3]), .alu_z(alu[2]), .alu_v(alu[1]), .alu_c(alu[0]),
    .BrTaken(br_o[0]), .UncondBr(ub_o[0]), .flags(fl0), .squash(sq_o[0]),
    .taken_count(cnt0));

  branch_decode #(.SQUASH_SLOTS(2), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
    .cbz_zero(cbz_zero), .alu_n(alu[3]), .alu_z(alu[2]), .alu_v(alu[1]), .alu_c(alu[0]),
    .BrTaken(br_o[1]), .UncondBr(ub_o[1]), .flags(fl1), .squash(sq_o[1]),
    .taken_count(cnt1));

  branch_decode #(.SQUASH_SLOTS(0), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
    .cbz_zero(cbz_zero), .alu_n(alu[3]), .alu_z(alu[2]), .alu_v(alu[1]), .alu_c(alu[0]),
    .BrTaken(br_o[2]), .UncondBr(ub_o[2]), .flags(fl2), .squash(sq_o[2]),
    .taken_count(cnt2));

  function automatic logic [3:0] get_fl(input int d);
    return (d == 0) ? fl0 : (d == 1) ? fl1 : fl2;
  endfunction

  function automatic logic [15:0] get_cnt(input int d);
    return (d == 0) ? cnt0 : (d == 1) ? cnt1 : {12'd0, cnt2};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1: drive, check combinational outputs mid-cycle,
  // then check registered outputs just after the next rising edge.
  task automatic step(input int d, input string tag, input logic v, input logic [31:0] ins,
                      input logic cz, input logic [3:0] alu_in,
                      input logic e_br, input logic e_ub, input logic [3:0] e_fl,
                      input logic e_sq, input logic [15:0] e_cnt);
    instr_valid = v;
    instruction = ins;
    cbz_zero    = cz;
    alu         = alu_in;
    #3;
    chk($sformatf("dut%0d %s BrTaken", d, tag), 32'(br_o[d]), 32'(e_br));
    chk($sformatf("dut%0d %s UncondBr", d, tag), 32'(ub_o[d]), 32'(e_ub));
    @(posedge clk);
    #1;
    chk($sformatf("dut%0d %s flags", d, tag), 32'(get_fl(d)), 32'(e_fl));
    chk($sformatf("dut%0d %s squash", d, tag), 32'(sq_o[d]), 32'(e_sq));
    chk($sformatf("dut%0d %s taken_count", d, tag), 32'(get_cnt(d)), 32'(e_cnt));
  endtask

  // Mid-cycle asynchronous reset with immediate checks on every instance
  task automatic mid_reset(input string tag);
    instr_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("dut%0d %s rst flags", d, tag), 32'(get_fl(d)), 32'd0);
      chk($sformatf("dut%0d %s rst squash", d, tag), 32'(sq_o[d]), 32'd0);
      chk($sformatf("dut%0d %s rst count", d, tag), 32'(get_cnt(d)), 32'd0);
      chk($sformatf("dut%0d %s rst BrTaken", d, tag), 32'(br_o[d]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic        cz;
    logic [3:0]  alu;
    logic        e_br;
    logic        e_ub;
    logic [3:0]  e_fl;
    logic        e_sq;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[23];

  initial begin
    // {v, instruction, cbz_zero, alu NZVC, BrTaken, UncondBr, flags', squash', count'}
    vecs[0]  = '{1'b1, I_SUBS,         1'b0, 4'b1000, 1'b0, 1'b0, 4'b1000, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, bcond(4'b1011), 1'b0, 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 16'd1}; // B.LT
    vecs[2]  = '{1'b1, I_ADDS,         1'b0, 4'b0100, 1'b0, 1'b0, 4'b1000, 1'b0, 16'd1}; // squashed
    vecs[3]  = '{1'b1, I_B,            1'b0, 4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 16'd2};
    vecs[4]  = '{1'b1, I_B,            1'b0, 4'b1111, 1'b0, 1'b0, 4'b1000, 1'b0, 16'd2}; // squashed
    vecs[5]  = '{1'b1, I_CBZ,          1'b0, 4'b1111, 1'b0, 1'b0, 4'b1000, 1'b0, 16'd2};
    vecs[6]  = '{1'b1, I_CBZ,          1'b1, 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 16'd3};
    vecs[7]  = '{1'b0, I_B,            1'b1, 4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 16'd3}; // bubble
    vecs[8]  = '{1'b1, I_NOP,          1'b0, 4'b1111, 1'b0, 1'b0, 4'b1000, 1'b0, 16'd3};
    vecs[9]  = '{1'b1, bcond(4'b0000), 1'b0, 4'b1111, 1'b0, 1'b0, 4'b1000, 1'b0, 16'd3}; // EQ
    vecs[10] = '{1'b1, bcond(4'b1010), 1'b0, 4'b1111, 1'b0, 1'b0, 4'b1000, 1'b0, 16'd3}; // GE
    vecs[11] = '{1'b1, I_ADDS,         1'b0, 4'b0110, 1'b0, 1'b0, 4'b0110, 1'b0, 16'd3};
    vecs[12] = '{1'b1, bcond(4'b1100), 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0110, 1'b0, 16'd3}; // GT
    vecs[13] = '{1'b1, bcond(4'b1101), 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0110, 1'b1, 16'd4}; // LE
    vecs[14] = '{1'b1, I_NOP,          1'b0, 4'b0000, 1'b0, 1'b0, 4'b0110, 1'b0, 16'd4};
    vecs[15] = '{1'b1, I_SUBS,         1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 16'd4};
    vecs[16] = '{1'b1, bcond(4'b1000), 1'b0, 4'b1110, 1'b1, 1'b0, 4'b0001, 1'b1, 16'd5}; // HI
    vecs[17] = '{1'b0, I_NOP,          1'b0, 4'b1110, 1'b0, 1'b0, 4'b0001, 1'b1, 16'd5};
    vecs[18] = '{1'b1, I_NOP,          1'b0, 4'b1110, 1'b0, 1'b0, 4'b0001, 1'b0, 16'd5};
    vecs[19] = '{1'b1, bcond(4'b1111), 1'b0, 4'b1110, 1'b1, 1'b0, 4'b0001, 1'b1, 16'd6}; // NV
    vecs[20] = '{1'b1, I_NOP,          1'b0, 4'b1110, 1'b0, 1'b0, 4'b0001, 1'b0, 16'd6};
    vecs[21] = '{1'b1, bcond(4'b0011), 1'b0, 4'b1110, 1'b0, 1'b0, 4'b0001, 1'b0, 16'd6}; // LO
    vecs[22] = '{1'b0, I_B,            1'b0, 4'b1110, 1'b0, 1'b0, 4'b0001, 1'b0, 16'd6}; // bubble

    rst         = 1'b1;
    instruction = 32'd0;
    instr_valid = 1'b0;
    cbz_zero    = 1'b0;
    alu         = 4'd0;

    // Power-on reset, checked immediately after the asynchronous assertion
    #1;
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("dut%0d por flags", d), 32'(get_fl(d)), 32'd0);
      chk($sformatf("dut%0d por squash", d), 32'(sq_o[d]), 32'd0);
      chk($sformatf("dut%0d por count", d), 32'(get_cnt(d)), 32'd0);
      chk($sformatf("dut%0d por BrTaken", d), 32'(br_o[d]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table on the default instance
    for (int i = 0; i < 23; i++) begin
      step(0, $sformatf("vec%0d", i), vecs[i].v, vecs[i].ins, vecs[i].cz, vecs[i].alu,
           vecs[i].e_br, vecs[i].e_ub, vecs[i].e_fl, vecs[i].e_sq, vecs[i].e_cnt);
    end

    // Reset during a squash aborts it; next instruction is live
    step(0, "pre_rst_b", 1'b1, I_B, 1'b0, 4'hF, 1'b1, 1'b1, 4'b0001, 1'b1, 16'd7);
    mid_reset("midsq");
    step(0, "post_rst_b", 1'b1, I_B, 1'b0, 4'hF, 1'b1, 1'b1, 4'b0000, 1'b1, 16'd1);

    // Two-slot squash with bubbles interleaved
    mid_reset("sq2");
    step(1, "sq2_b",    1'b1, I_B,    1'b0, 4'hF, 1'b1, 1'b1, 4'd0, 1'b1, 16'd1);
    step(1, "sq2_bub1", 1'b0, I_B,    1'b0, 4'hF, 1'b0, 1'b0, 4'd0, 1'b1, 16'd1);
    step(1, "sq2_adds", 1'b1, I_ADDS, 1'b0, 4'hF, 1'b0, 1'b0, 4'd0, 1'b1, 16'd1);
    step(1, "sq2_bub2", 1'b0, I_B,    1'b0, 4'hF, 1'b0, 1'b0, 4'd0, 1'b1, 16'd1);
    step(1, "sq2_b2",   1'b1, I_B,    1'b0, 4'hF, 1'b0, 1'b0, 4'd0, 1'b0, 16'd1);
    step(1, "sq2_b3",   1'b1, I_B,    1'b0, 4'hF, 1'b1, 1'b1, 4'd0, 1'b1, 16'd2);

    // No-squash instance: 20 back-to-back taken branches saturate at 15
    mid_reset("sat");
    for (int i = 0; i < 20; i++) begin
      step(2, $sformatf("sat%0d", i), 1'b1, I_B, 1'b0, 4'h0, 1'b1, 1'b1, 4'd0, 1'b0,
           (i < 15) ? 16'(i + 1) : 16'd15);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_branch_decode
`default_nettype wire
